// File: rtl/uart_tx_frame_if.sv
// Parallel-side request and serial-side status of the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input TX_OUT, Busy);
  modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start, DATA_WIDTH bits LSB-first, optional parity, one stop.
// Each bit is held CLKS_PER_BIT cycles; TX_OUT and Busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_frame_if.slave tx_if
);
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shr_q, shr_d;
  logic                  par_q, par_d;
  logic                  pen_q, pen_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_end;

  assign bit_end      = (pre_q == PW'(CLKS_PER_BIT - 1));
  assign tx_if.TX_OUT = tx_q;
  assign tx_if.Busy   = busy_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      pre_q   <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    par_d   = par_q;
    pen_d   = pen_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    if (state_q != IDLE) pre_d = bit_end ? '0 : pre_q + 1'b1;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_if.DATA_VALID) begin
          shr_d   = tx_if.P_DATA;
          pen_d   = tx_if.PAR_EN;
          // odd parity is the XNOR-reduce, i.e. the even bit inverted
          par_d   = (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          pre_d   = '0;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = shr_q[0];
        shr_d   = shr_q >> 1;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          state_d = pen_q ? PARITY : STOP;
          tx_d    = pen_q ? par_q : 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
          tx_d  = shr_q[0];
          shr_d = shr_q >> 1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Transmit-side serializer for the UART link; it is the counterpart of the receiver's parity checker and deserializer.
- Accepts a parallel byte with a valid strobe, builds a frame (start, data LSB-first, optional parity, one stop bit) and drives the serial line.
- Parity uses the same PAR_EN/PAR_TYP convention as the receive path, so an RX instance checks the frame with no error.
- Sits between the system-side data source and the TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- CLKS_PER_BIT, 1, CLK cycles each serial bit is held. Legal range 1..256; 1 means CLK is the bit clock.

Ports:
- CLK  input  1  system/bit clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-low; sampled on the CLK rising edge.
- P_DATA  input  DATA_WIDTH  parallel data to send.
- DATA_VALID  input  1  request; accepted only in IDLE.
- PAR_EN  input  1  1 = insert parity bit; latched at accept.
- PAR_TYP  input  1  0 = even, 1 = odd; latched at accept.
- TX_OUT  output  1  serial line, registered; idle level 1.
- Busy  output  1  registered; 1 while a frame is in progress.

Behaviour:
- Reset: on any CLK edge with RST=0, the block does all of the following, regardless of state:
  - state <= IDLE; TX_OUT <= 1; Busy <= 0.
  - bit counter, prescale counter, data shift register, parity register and latched PAR_EN all <= 0.
- A reset mid-frame truncates the frame immediately; no stop bit is forced beyond TX_OUT=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - At an edge with DATA_VALID=1, latch P_DATA, PAR_EN and PAR_TYP, and compute the parity bit:
    - PAR_TYP=0: XOR-reduce of data.
    - PAR_TYP=1: XNOR-reduce of data.
  - Same edge: state <= START, TX_OUT <= 0, Busy <= 1, prescale counter <= 0.
- Latency: the start bit appears on TX_OUT one edge after DATA_VALID is sampled.
- Bit timing:
  - Each state holds its TX_OUT value for exactly CLKS_PER_BIT cycles.
  - The prescale counter counts 0..CLKS_PER_BIT-1; the state advances on the edge where the count equals CLKS_PER_BIT-1.
  - With CLKS_PER_BIT=1, the bit advances every edge.
- START -> DATA: TX_OUT <= data[0]; bit counter <= 0.
- DATA:
  - On each bit boundary, the bit counter increments and TX_OUT <= data[counter+1].
  - After bit DATA_WIDTH-1 ends: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = latched parity bit; then go to STOP.
- STOP:
  - TX_OUT=1 for one bit time.
  - At the end of that bit time: state <= IDLE, Busy <= 0.
  - Busy stays 1 for the whole stop bit.
- Frame length: (DATA_WIDTH+2+PAR_EN)*CLKS_PER_BIT cycles of Busy=1. There is at least one IDLE cycle between frames.
- Handshake and latching:
  - DATA_VALID is ignored while Busy=1, including during the final stop cycle.
  - Changes on P_DATA, PAR_EN and PAR_TYP after accept have no effect on the current frame.
  - The upstream source holds DATA_VALID until it sees Busy rise, or pulses it only when Busy=0.
- No X on TX_OUT or Busy after the first reset edge.

Test Plan:
- Reset: RST=0 for 2 edges with DATA_VALID=1 and P_DATA=0xFF -> TX_OUT=1, Busy=0 throughout; no frame starts until RST=1.
- Even parity, CLKS_PER_BIT=1: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID pulse:
  - TX_OUT from next edge = 0, 1,0,1,0,0,1,0,1, 0, 1.
  - Busy=1 for exactly 11 cycles, then 0.
- Odd parity: same as above with PAR_TYP=1 -> parity bit=1; all other bits identical. A loopback RX instance reports par_err=0. Forcing the parity bit inverted gives par_err=1.
- No parity, CLKS_PER_BIT=4: P_DATA=0x3C, PAR_EN=0:
  - TX_OUT = 0, 0,0,1,1,1,1,0,0, 1, each held 4 cycles.
  - Busy=1 for 40 cycles.
- Mid-frame interference: during DATA of a 0x81 frame, pulse DATA_VALID with P_DATA=0x00 and toggle PAR_TYP -> original frame unchanged, no second frame. A DATA_VALID asserted in the first IDLE cycle after Busy falls starts the next frame.
- Reset mid-frame: assert RST=0 while the 3rd data bit is on the line:
  - Next edge TX_OUT=1, Busy=0.
  - After release, a new 0x55 even-parity frame transmits correctly (parity bit 0).
